dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's load/store port.
- Accepts the core's MEM-stage request: ram_addr, Wr_mem_data, W_en, R_en, RW_type.
- Returns Rd_mem_data combinationally in the same cycle, already sign/zero-extended.
- Performs byte-lane-masked synchronous stores, traps misaligned or illegal accesses into a sticky fault register, and keeps load/store event counters for bring-up.

Parameters:
- ADDR_W, 8, word-index width; memory holds 2**ADDR_W 32-bit words.
- CNT_W, 16, width of each access counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- ram_addr  input  32  byte address from the core.
- Wr_mem_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- W_en  input  1  store request this cycle.
- R_en  input  1  load request this cycle.
- RW_type  input  3  access type (func3 encoding).
- Rd_mem_data  output  32  load result, extended per RW_type.
- fault  output  1  sticky misaligned/illegal-access flag.
- fault_addr  output  32  ram_addr of the captured fault.
- fault_info  output  4  {is_store, RW_type} of the captured fault.
- fault_clr  input  1  clears the fault register.
- load_cnt  output  CNT_W  count of accepted loads.
- store_cnt  output  CNT_W  count of accepted stores.

Behaviour:
- Reset values:
  - fault=0, fault_addr=0, fault_info=0, load_cnt=0, store_cnt=0.
  - Memory array is not cleared.
  - Rd_mem_data is combinational (0 whenever R_en=0).
- Addressing:
  - Word index = ram_addr[ADDR_W+1:2].
  - ram_addr[31:ADDR_W+2] is ignored, so addresses alias.
  - Little-endian lanes; byte offset = ram_addr[1:0].
- RW_type encoding:
  - 000 byte signed; 001 half signed; 010 word; 100 byte unsigned; 101 half unsigned.
  - 011, 110 and 111 are illegal.
  - For stores, 000 and 100 both mean byte; 001 and 101 both mean half.
- Access is bad when any of these holds:
  - RW_type is illegal.
  - Half access with ram_addr[0]=1.
  - Word access with ram_addr[1:0]≠00.
- Load (R_en=1, not bad):
  - Selects the addressed byte or half from the current array word.
  - Signed types sign-extend; unsigned types zero-extend.
  - Zero latency.
- Store (W_en=1, not bad):
  - At the rising edge, writes only the selected lanes, using data shifted to the byte offset.
  - Other lanes are unchanged.
  - Visible to loads from the next cycle.
- Bad access:
  - Load returns 0; store writes nothing.
  - Counters do not increment.
  - If fault=0: next edge sets fault=1 and captures fault_addr and fault_info.
  - If fault=1: first capture is held and later faults are dropped.
- fault_clr:
  - Clears fault, fault_addr and fault_info at the next edge.
  - A bad access in the same cycle as fault_clr wins: it is captured and fault stays 1.
- W_en and R_en both high:
  - The store is performed.
  - Rd_mem_data returns the pre-write array contents (read-old).
  - Both counters increment if not bad.
  - A bad access is captured once, with is_store=1.
- Counters:
  - Increment by 1 per accepted access.
  - Wrap from all-ones to 0.
- rst asserted together with a request: reset wins for all registers; the store still updates the array.
- No internal state machine beyond the fault capture (IDLE/HELD); there is no stall or back-pressure, and every request completes in its cycle.

Test Plan:
- Word store then load:
  - Stimulus: W_en, RW_type=010, addr 0x10, data 0xDEADBEEF; next cycle R_en, 010, addr 0x10.
  - Required: Rd_mem_data=0xDEADBEEF; store_cnt=1, load_cnt=1.
- Byte lanes and extension:
  - Stimulus: word at 0x20 = 0x00000000; store byte 0x80 at 0x23.
  - Required: 010 load gives 0x80000000; 000 load at 0x23 gives 0xFFFFFF80; 100 load at 0x23 gives 0x00000080.
- Half store and load:
  - Stimulus: store half 0x8001 at 0x42 over word 0x11223344.
  - Required: word reads 0x80013344; 001 load at 0x42 gives 0xFFFF8001; 101 load gives 0x00008001.
- Misaligned store:
  - Stimulus: word store at 0x21, data 0xFFFFFFFF.
  - Required: array unchanged; fault=1, fault_addr=0x21, fault_info=1_010; store_cnt unchanged.
  - Follow-up: a second bad load leaves the capture intact; fault_clr alone clears it to 0.
- Simultaneous and boundary events:
  - Stimulus: R_en and W_en together at 0x8, old word 0x1, new word 0x2.
  - Required: same-cycle read gives 0x1; next read gives 0x2.
  - Stimulus: address 0x400 with ADDR_W=8.
  - Required: aliases to word index 0.
  - Stimulus: fault_clr with a concurrent bad access.
  - Required: fault stays 1 with the new capture.
- Reset and counter wrap:
  - Stimulus: CNT_W=4, 17 loads.
  - Required: load_cnt=1.
  - Stimulus: assert rst.
  - Required: counters and fault go to 0; previously stored memory data is still readable.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the far side of the core's
// load/store port. It returns load data combinationally, already sign- or
// zero-extended. Stores are byte-lane masked and take effect at the clock
// edge. Misaligned or illegal accesses are trapped into a sticky fault
// register, and accepted loads and stores are counted for bring-up.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   ram_addr       byte address; bits above the word index alias
//   Wr_mem_data    right-aligned store data
//   W_en, R_en     store / load request for this cycle
//   RW_type        func3 access type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
//   Rd_mem_data    extended load result (0 when no valid load)
//   fault          sticky bad-access flag
//   fault_addr     address of the captured bad access
//   fault_info     {is_store, RW_type} of the captured bad access
//   fault_clr      clears the fault capture
//   load_cnt       accepted loads, wrapping
//   store_cnt      accepted stores, wrapping
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ram_addr,
  input  logic [31:0]       Wr_mem_data,
  input  logic              W_en,
  input  logic              R_en,
  input  logic [2:0]        RW_type,
  output logic [31:0]       Rd_mem_data,
  output logic              fault,
  output logic [31:0]       fault_addr,
  output logic [3:0]        fault_info,
  input  logic              fault_clr,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  logic [31:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        off;
  logic [4:0]        shamt;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              is_signed;
  logic              bad;
  logic [31:0]       rd_word;
  logic [31:0]       lane;
  logic [31:0]       wdata;
  logic [3:0]        be;

  // Upper address bits are intentionally ignored so addresses alias.
  logic              unused_addr;
  assign unused_addr = ^ram_addr[31:ADDR_W+2];

  assign word_idx  = ram_addr[ADDR_W+1:2];
  assign off       = ram_addr[1:0];
  assign shamt     = {off, 3'b000};

  // Bit 2 of func3 only selects signedness, so 000/100 are byte and
  // 001/101 are half; 010 is the sole word encoding.
  assign is_byte   = (RW_type[1:0] == 2'b00);
  assign is_half   = (RW_type[1:0] == 2'b01);
  assign is_word   = (RW_type == 3'b010);
  assign is_signed = ~RW_type[2];

  assign bad = (W_en | R_en) &
               (~(is_byte | is_half | is_word) |
                (is_half & off[0]) |
                (is_word & (off != 2'b00)));

  // Load path: the array is read asynchronously, so a same-cycle store is
  // not yet visible (read-old).
  assign rd_word = mem[word_idx];
  assign lane    = rd_word >> shamt;

  always_comb begin
    Rd_mem_data = '0;
    if (R_en && !bad) begin
      if (is_byte)
        Rd_mem_data = {{24{is_signed & lane[7]}}, lane[7:0]};
      else if (is_half)
        Rd_mem_data = {{16{is_signed & lane[15]}}, lane[15:0]};
      else
        Rd_mem_data = rd_word;
    end
  end

  // Store path: shift right-aligned data to the byte offset and enable
  // only the addressed lanes.
  assign wdata = Wr_mem_data << shamt;

  always_comb begin
    be = '0;
    if (is_byte)
      be = 4'b0001 << off;
    else if (is_half)
      be = 4'b0011 << off;
    else if (is_word)
      be = 4'b1111;
  end

  // The array has no reset; a store issued during reset still lands.
  always_ff @(posedge clk) begin
    if (W_en && !bad) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i])
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Fault capture: fault itself is the IDLE/HELD state. A bad access that
  // coincides with fault_clr overrides the clear and is captured fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= '0;
      fault_info <= '0;
    end else if (bad && (!fault || fault_clr)) begin
      fault      <= 1'b1;
      fault_addr <= ram_addr;
      fault_info <= {W_en, RW_type};
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_addr <= '0;
      fault_info <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (R_en && !bad)
        load_cnt <= load_cnt + 1'b1;
      if (W_en && !bad)
        store_cnt <= store_cnt + 1'b1;
    end
  end

endmodule
